multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: opcode  input  6  instruction[31:26] from the instruction register.
REQ-004 SHALL have port: mem_ready  input  1  memory access completes this cycle.
REQ-005 SHALL have ports, each output 1 bit: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst.
REQ-006 SHALL have ports, each output 2 bits: ALUOp, ALUSrcB, PCSource.
REQ-007 SHALL have port: illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-008 SHALL have port: state  output  4  current state encoding, for debug.

Function
REQ-009 SHALL implement states FETCH(0), DECODE(1), MEM_ADDR(2), MEM_READ(3), MEM_WB(4), MEM_WRITE(5), EXECUTE(6), R_WB(7), BRANCH(8), JUMP(9), ADDI_EXEC(10), ADDI_WB(11); encodings 12-15 unused.
REQ-010 SHALL decode opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
REQ-011 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=1 and PCWrite=1 only in the cycle mem_ready=1; stay in FETCH while mem_ready=0, go to DECODE when mem_ready=1.
REQ-012 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next state by opcode: lw/sw->MEM_ADDR, R->EXECUTE, beq->BRANCH, j->JUMP, addi->ADDI_EXEC, any other->FETCH with illegal_op=1 for that cycle.
REQ-013 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; lw->MEM_READ, sw->MEM_WRITE.
REQ-014 MEM_READ: MemRead=1, IorD=1; hold until mem_ready=1, then MEM_WB.
REQ-015 MEM_WRITE: MemWrite=1, IorD=1; hold until mem_ready=1, then FETCH.
REQ-016 MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0; then FETCH.
REQ-017 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10; then R_WB. R_WB: RegWrite=1, MemtoReg=0, RegDst=1; then FETCH.
REQ-018 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; then FETCH.
REQ-019 JUMP: PCWrite=1, PCSource=10; then FETCH.
REQ-020 ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00; then ADDI_WB. ADDI_WB: RegWrite=1, MemtoReg=0, RegDst=0; then FETCH.
REQ-021 Every output not listed for a state SHALL be 0 in that state.
REQ-022 MemRead and MemWrite SHALL never be 1 in the same cycle; RegWrite and PCWrite SHALL never be 1 in the same cycle.
REQ-023 Outputs SHALL be a combinational decode of state, plus mem_ready for IRWrite/PCWrite and opcode for illegal_op; all state transitions occur on the rising edge of clk.
REQ-024 An unused state encoding SHALL drive all control outputs to 0 and return to FETCH on the next edge.
REQ-025 Cycle counts with mem_ready held 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-026 While rst_n=0 at a clk edge, state SHALL load FETCH, whatever the current state, including mid-wait in MEM_READ or MEM_WRITE.
REQ-027 While rst_n=0, all control outputs and illegal_op SHALL be 0.
REQ-028 After rst_n returns to 1, the first active cycle SHALL be FETCH.

Structure
REQ-029 Package mips_ctrl_pkg SHALL hold the state encodings, the opcode constants and the ALUOp/ALUSrcB/PCSource code constants.
REQ-030 Output decoding SHALL be a sub-module ctrl_decode (state, opcode, mem_ready -> control outputs); multicycle_control holds only the state register and next-state logic.

Verification
REQ-031 Reset held low 2 cycles during MEM_READ wait -> state=0, all outputs 0; after release, state=0 with MemRead=1.
REQ-032 lw (100011), mem_ready=1 throughout -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-033 sw (101011), mem_ready=0 for 3 cycles in MEM_WRITE -> MemWrite=1 for 4 consecutive cycles, then state=0.
REQ-034 R-type (000000) -> states 0,1,6,7,0; ALUOp=10 in state 6; RegDst=1 and RegWrite=1 in state 7.
REQ-035 beq then j -> BRANCH has PCWriteCond=1, PCSource=01, PCWrite=0; JUMP has PCWrite=1, PCSource=10.
REQ-036 opcode 111111 in DECODE -> illegal_op=1 for exactly 1 cycle, next state=0, RegWrite and MemWrite stay 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes,
// datapath mux/ALU codes and the bundled control-word type.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecute  = 4'd6,
        StRWb      = 4'd7,
        StBranch   = 4'd8,
        StJump     = 4'd9,
        StAddiExec = 4'd10,
        StAddiWb   = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic [1:0] SrcBReg      = 2'b00;
    localparam logic [1:0] SrcBFour     = 2'b01;
    localparam logic [1:0] SrcBImm      = 2'b10;
    localparam logic [1:0] SrcBImmShift = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OpRtype) || (op == OpLw) || (op == OpSw) ||
               (op == OpBeq) || (op == OpJ) || (op == OpAddi);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control-word decode from the current FSM state; en_i low
// (reset asserted) forces every output to zero.
module ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    input  logic       en_i,
    output ctrl_t      ctrl_o,
    output logic       illegal_op_o
);

    always_comb begin
        ctrl_o       = '0;
        illegal_op_o = 1'b0;
        if (en_i) begin
            unique case (state_i)
                StFetch: begin
                    ctrl_o.mem_read  = 1'b1;
                    ctrl_o.alu_src_b = SrcBFour;
                    // IR and PC only capture once the fetch actually lands
                    ctrl_o.ir_write  = mem_ready_i;
                    ctrl_o.pc_write  = mem_ready_i;
                end
                StDecode: begin
                    ctrl_o.alu_src_b = SrcBImmShift;
                    illegal_op_o     = !is_legal_op(opcode_i);
                end
                StMemAddr, StAddiExec: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_src_b = SrcBImm;
                end
                StMemRead: begin
                    ctrl_o.mem_read = 1'b1;
                    ctrl_o.i_or_d   = 1'b1;
                end
                StMemWrite: begin
                    ctrl_o.mem_write = 1'b1;
                    ctrl_o.i_or_d    = 1'b1;
                end
                StMemWb: begin
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.mem_to_reg = 1'b1;
                end
                StExecute: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_op    = AluOpFunct;
                end
                StRWb: begin
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.reg_dst   = 1'b1;
                end
                StBranch: begin
                    ctrl_o.alu_src_a     = 1'b1;
                    ctrl_o.alu_op        = AluOpSub;
                    ctrl_o.pc_write_cond = 1'b1;
                    ctrl_o.pc_source     = PcSrcAluOut;
                end
                StJump: begin
                    ctrl_o.pc_write  = 1'b1;
                    ctrl_o.pc_source = PcSrcJump;
                end
                StAddiWb: begin
                    ctrl_o.reg_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register and next-state logic, with the
// control-word decode delegated to ctrl_decode.
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_e state_q, state_d;
    ctrl_t  ctrl;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:    if (mem_ready) state_d = StDecode;
            StDecode: begin
                unique case (opcode)
                    OpLw, OpSw: state_d = StMemAddr;
                    OpRtype:    state_d = StExecute;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    OpAddi:     state_d = StAddiExec;
                    default:    state_d = StFetch;
                endcase
            end
            // Opcode is held in the IR; anything other than sw/lw here aborts to fetch
            StMemAddr:  state_d = (opcode == OpSw) ? StMemWrite :
                                  (opcode == OpLw) ? StMemRead  : StFetch;
            StMemRead:  if (mem_ready) state_d = StMemWb;
            StMemWrite: if (mem_ready) state_d = StFetch;
            StExecute:  state_d = StRWb;
            StAddiExec: state_d = StAddiWb;
            default:    state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    ctrl_decode u_ctrl_decode (
        .state_i      (state_q),
        .opcode_i     (opcode),
        .mem_ready_i  (mem_ready),
        .en_i         (rst_n),
        .ctrl_o       (ctrl),
        .illegal_op_o (illegal_op)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign ALUOp       = ctrl.alu_op;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign PCSource    = ctrl.pc_source;
    assign state       = state_q;

endmodule
